// File: rtl/mul_wb_stage_pkg.sv
// Shared multiply-writeback types: funct3 encodings and the E->M control bundle.
// Consumed by mul_wb_stage (optional MUL_HAZARD_COUNT_EN feature) and mul_result_sel.
package mdu_pkg;

   localparam logic [2:0] MUL_F3    = 3'b000;
   localparam logic [2:0] MULH_F3   = 3'b001;
   localparam logic [2:0] MULHSU_F3 = 3'b010;
   localparam logic [2:0] MULHU_F3  = 3'b011;

   typedef struct packed {
      logic       mul;
      logic [2:0] funct3;
      logic       w64;
      logic [4:0] rd;
   } mul_ctrl_t;

endpackage

// File: rtl/mul_wb_stage_if.sv
// Pipeline-facing bundle of mul_wb_stage: stage controls, Execute/Decode fields,
// product in, Writeback result and Decode stall out.
interface mul_wb_stage_if #(parameter int XLEN = 64);

   logic                StallM;
   logic                FlushM;
   logic                StallW;
   logic                FlushW;
   logic                MulE;
   logic [2:0]          Funct3E;
   logic                W64E;
   logic [4:0]          RdE;
   logic [4:0]          Rs1D;
   logic [4:0]          Rs2D;
   logic [2*XLEN-1:0]   ProdM;
   logic [XLEN-1:0]     MulResultW;
   logic                MulValidW;
   logic [4:0]          RdW;
   logic                MulHazardD;

   modport master (
      output StallM, FlushM, StallW, FlushW, MulE, Funct3E, W64E, RdE, Rs1D, Rs2D, ProdM,
      input  MulResultW, MulValidW, RdW, MulHazardD
   );

   modport slave (
      input  StallM, FlushM, StallW, FlushW, MulE, Funct3E, W64E, RdE, Rs1D, Rs2D, ProdM,
      output MulResultW, MulValidW, RdW, MulHazardD
   );

endinterface

// File: rtl/mul_wb_stage_result_sel.sv
// Memory-stage result slice: low word, high word, or sign-extended 32-bit word of
// the double-width product. Purely combinational.
module mul_result_sel
   import mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                i_mul,
   input  logic [2:0]          i_funct3,
   input  logic                i_w64,
   input  logic [2*XLEN-1:0]   i_prod,
   output logic [XLEN-1:0]     o_result
);

   logic [XLEN-1:0] w_word_sext;
   logic            w_w64_ok;

   // The W-variant only exists on RV64; on RV32 it collapses to the illegal case.
   generate
      if (XLEN == 64) begin : g_rv64
         assign w_word_sext = {{32{i_prod[31]}}, i_prod[31:0]};
         assign w_w64_ok    = 1'b1;
      end else begin : g_rv32
         assign w_word_sext = '0;
         assign w_w64_ok    = 1'b0;
      end
   endgenerate

   always_comb begin
      o_result = '0;
      if (i_mul && !i_funct3[2]) begin
         if (i_w64) begin
            if (w_w64_ok && i_funct3 == MUL_F3) o_result = w_word_sext;
         end else if (i_funct3 == MUL_F3) begin
            o_result = i_prod[XLEN-1:0];
         end else begin
            o_result = i_prod[2*XLEN-1:XLEN];
         end
      end
   end

endmodule

// File: rtl/mul_wb_stage.sv
// Tracks a multiply from Execute to Writeback, selects the result slice in Memory and
// raises the Decode load-use stall. Define MUL_HAZARD_COUNT_EN for a stall counter.
module mul_wb_stage
   import mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   mul_wb_stage_if.slave      bus
`ifdef MUL_HAZARD_COUNT_EN
   ,
   output logic [31:0]        MulHazardCount
`endif
);

   mul_ctrl_t          w_ctrlE;
   mul_ctrl_t          r_ctrlM;
   logic [XLEN-1:0]    w_resultM;
   logic               w_validM;
   logic [XLEN-1:0]    r_resultW;
   logic               r_validW;
   logic [4:0]         r_rdW;
   logic               w_hazardD;

   assign w_ctrlE = '{mul: bus.MulE, funct3: bus.Funct3E, w64: bus.W64E, rd: bus.RdE};

   // flopenrc: a stalled register ignores flush.
   always_ff @(posedge clk) begin
      if (!reset_n)         r_ctrlM <= '0;
      else if (!bus.StallM) r_ctrlM <= bus.FlushM ? '0 : w_ctrlE;
   end

   mul_result_sel #(.XLEN(XLEN)) u_sel (
      .i_mul    (r_ctrlM.mul),
      .i_funct3 (r_ctrlM.funct3),
      .i_w64    (r_ctrlM.w64),
      .i_prod   (bus.ProdM),
      .o_result (w_resultM)
   );

   // Divide encodings share the pipe but are not ours to write back.
   assign w_validM = r_ctrlM.mul & ~r_ctrlM.funct3[2];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_resultW <= '0;
         r_validW  <= 1'b0;
         r_rdW     <= '0;
      end else if (!bus.StallW) begin
         if (bus.FlushW) begin
            r_resultW <= '0;
            r_validW  <= 1'b0;
            r_rdW     <= '0;
         end else begin
            r_resultW <= w_resultM;
            r_validW  <= w_validM;
            r_rdW     <= r_ctrlM.rd;
         end
      end
   end

   assign bus.MulResultW = r_resultW;
   assign bus.MulValidW  = r_validW;
   assign bus.RdW        = r_rdW;

   // One bubble suffices: a mul already in M is forwarded from W to the consumer.
   assign w_hazardD = bus.MulE & (bus.RdE != 5'd0) &
                      ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D));
   assign bus.MulHazardD = w_hazardD;

`ifdef MUL_HAZARD_COUNT_EN
   logic [31:0] r_hazard_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_hazard_cnt <= '0;
      else if (w_hazardD && !bus.StallM && r_hazard_cnt != 32'hFFFF_FFFF)
         r_hazard_cnt <= r_hazard_cnt + 32'd1;
   end

   assign MulHazardCount = r_hazard_cnt;
`endif

   a_w64_legal: assert property (@(posedge clk) disable iff (!reset_n)
      !(r_ctrlM.mul && r_ctrlM.w64 && !r_ctrlM.funct3[2] && r_ctrlM.funct3 != MUL_F3));

endmodule

// File: doc/mul_wb_stage.md
Name: mul_wb_stage

Overview:
- Downstream consumer of the multiplier's double-width product (ProdM).
- Tracks the multiply instruction from the Execute stage to Writeback and picks the architectural result slice in the Memory stage: low word, high word, or sign-extended 32-bit word.
- Registers the result into Writeback.
- Raises a one-cycle Decode stall when a dependent instruction would read the product before it exists.

Parameters:
- XLEN, 64, integer register width (32 or 64); the W-variant path exists only when XLEN=64.

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- StallM  in  1  hold the E->M register
- FlushM  in  1  clear the E->M register
- StallW  in  1  hold the M->W register
- FlushW  in  1  clear the M->W register
- MulE  in  1  a valid multiply is in Execute
- Funct3E  in  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- W64E  in  1  MULW (RV64 only)
- RdE  in  5  destination register in Execute
- Rs1D  in  5  source register 1 in Decode
- Rs2D  in  5  source register 2 in Decode
- ProdM  in  2*XLEN  product from the multiplier, valid in Memory
- MulResultW  out  XLEN  selected result
- MulValidW  out  1  a multiply result is in Writeback
- RdW  out  5  destination of MulResultW
- MulHazardD  out  1  stall Decode/Fetch this cycle

Behaviour:
- Reset:
  - On a clk edge with reset_n=0, all state and outputs go to 0: MulM, Funct3M, W64M, RdM, MulResultW, MulValidW, RdW.
  - Reset dominates stall and flush.
  - Reset asserted mid-operation discards any in-flight multiply.
- E->M register (MulE, Funct3E, W64E, RdE):
  - Loads when StallM=0.
  - If FlushM=1 in a load cycle, it loads zeros.
  - FlushM is ignored while StallM=1 (flopenrc semantics).
- Result select (Memory stage, combinational; MulM=0 gives 0):
  - Funct3M=000, W64M=0: ProdM[XLEN-1:0].
  - Funct3M=001/010/011: ProdM[2*XLEN-1:XLEN].
  - Funct3M=000, W64M=1, XLEN=64: {32{ProdM[31]}, ProdM[31:0]}.
  - W64M=1 with Funct3M!=000 is illegal; the output is 0. Assertion in simulation.
  - Funct3M[2]=1 (divide encodings): treated as MulM=0.
- M->W register (selected result, MulM, RdM):
  - Loads when StallW=0.
  - FlushW=1 in a load cycle clears it.
- Latency: the product sampled at the end of cycle M appears on MulResultW in cycle W, one cycle after M.
- Hazard:
  - MulHazardD = MulE & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - A one-cycle bubble is enough: after it, the consumer in E forwards from W.
  - No hazard is raised for x0.
  - No hazard is raised for a mul in M; the W forwarding path covers it.
  - Rs1D==Rs2D==RdE counts as one hazard, not two cycles.
- Simultaneous StallM=1 and StallW=0:
  - W loads the M contents.
  - The pipeline controller must flush M in that case; this block does not enforce it.

Optional Feature:
- Macro: MUL_HAZARD_COUNT_EN.
- When defined:
  - Adds output MulHazardCount (32 bits).
  - Increments on every cycle MulHazardD=1 with StallM=0.
  - Saturates at 0xFFFF_FFFF.
  - Reset to 0.
- When undefined: no port and no counter logic.

Decomposition:
- Package mdu_pkg:
  - funct3 localparams MUL_F3=3'b000, MULH_F3=3'b001, MULHSU_F3=3'b010, MULHU_F3=3'b011.
  - A typedef struct for the E->M control bundle {mul, funct3, w64, rd}.
- Sub-module mul_result_sel: the combinational Memory-stage slice and sign-extend logic. All flops stay in mul_wb_stage.

Test Plan:
- MULH, XLEN=64, drive ProdM=128'hFFFF..FFFE (-1*2), no stalls -> MulResultW=64'hFFFF_FFFF_FFFF_FFFF two cycles after MulE; MulValidW=1, RdW=RdE.
- MUL, ProdM=128'h0000_0000_0000_0001_8000_0000_0000_0000 -> MulResultW=64'h8000_0000_0000_0000. MULHU with the same ProdM -> 64'h1.
- MULW, ProdM low=64'h0000_0000_FFFF_FFFE -> MulResultW=64'hFFFF_FFFF_FFFF_FFFE. With ProdM[31:0]=32'h7FFF_FFFE -> 64'h0000_0000_7FFF_FFFE.
- Hazard: MulE=1, RdE=5, Rs2D=5 -> MulHazardD=1. RdE=0, Rs1D=0 -> MulHazardD=0. RdE=5, Rs1D=Rs2D=6 -> 0.
- Stall/flush:
  - StallW=1 for 3 cycles -> MulResultW holds.
  - FlushW=1 with StallW=0 -> MulValidW=0 next cycle.
  - FlushM=1 with StallM=1 -> the M contents are retained.
- reset_n=0 for one edge while a mul is in M and W -> all outputs 0 next cycle, and no result appears afterwards. With MUL_HAZARD_COUNT_EN, 4 hazard cycles -> MulHazardCount=4.
